// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one SD sector-read engine between two requesters.
// Define SD_ARB_FIXED_PRIORITY_EN to make requester 0 always win simultaneous requests.
module sd_read_arbiter #(
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              card_ready,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [7:0]        data0,
    output logic              valid0,
    output logic              done0,
    output logic              err0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [7:0]        data1,
    output logic              valid1,
    output logic              done1,
    output logic              err1,

    output logic              sd_rd_req,
    output logic [ADDR_W-1:0] sd_rd_addr,
    input  logic              sd_rd_ack,
    input  logic [7:0]        sd_rd_data,
    input  logic              sd_rd_valid,
    input  logic              sd_rd_err,

    output logic              busy
);

    localparam int unsigned CNT_W  = (BLOCK_BYTES > 1)    ? $clog2(BLOCK_BYTES)    : 1;
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_FINISH,
        S_ABORT
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic [1:0]          gnt_q;
    logic [1:0]          valid_q;
    logic [1:0]          done_q;
    logic [1:0]          err_q;
    logic [7:0]          data0_q;
    logic [7:0]          data1_q;
    logic                sd_rd_req_q;
    logic [ADDR_W-1:0]   sd_rd_addr_q;

    logic                win_d;
    logic                active_d;
    logic                progress_d;
    logic                abort_d;
    logic [WDOG_W-1:0]   wdog_d;

`ifdef SD_ARB_FIXED_PRIORITY_EN
    always_comb begin
        win_d = ~req0;
    end
`else
    logic rr_ptr_q;

    always_comb begin
        win_d = (req0 && req1) ? rr_ptr_q : ~req0;
    end

    // Favour the other requester once the current block ends, either way.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 1'b0;
        end else if (state_q == S_FINISH || state_q == S_ABORT) begin
            rr_ptr_q <= ~owner_q;
        end
    end
`endif

    always_comb begin
        active_d   = (state_q == S_ISSUE) || (state_q == S_XFER);
        progress_d = ((state_q == S_ISSUE) && sd_rd_ack) ||
                     ((state_q == S_XFER)  && sd_rd_valid);
        abort_d    = active_d &&
                     (sd_rd_err || !card_ready || (!progress_d && wdog_q == WDOG_LIMIT));
        if (progress_d) begin
            wdog_d = '0;
        end else if (wdog_q == '1) begin
            wdog_d = wdog_q;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            wdog_q       <= '0;
            gnt_q        <= '0;
            valid_q      <= '0;
            done_q       <= '0;
            err_q        <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            sd_rd_req_q  <= 1'b0;
            sd_rd_addr_q <= '0;
        end else begin
            valid_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (card_ready && (req0 || req1)) begin
                        owner_q      <= win_d;
                        gnt_q        <= win_d ? 2'b10 : 2'b01;
                        sd_rd_addr_q <= win_d ? addr1 : addr0;
                        sd_rd_req_q  <= 1'b1;
                        wdog_q       <= '0;
                        data0_q      <= '0;
                        data1_q      <= '0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE, S_XFER: begin
                    wdog_q <= wdog_d;
                    // A byte arriving with an abort is still forwarded.
                    if (state_q == S_XFER && sd_rd_valid) begin
                        valid_q[owner_q] <= 1'b1;
                        if (owner_q) begin
                            data1_q <= sd_rd_data;
                        end else begin
                            data0_q <= sd_rd_data;
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (abort_d) begin
                        err_q[owner_q] <= 1'b1;
                        gnt_q          <= '0;
                        sd_rd_req_q    <= 1'b0;
                        state_q        <= S_ABORT;
                    end else if (state_q == S_ISSUE && sd_rd_ack) begin
                        sd_rd_req_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_XFER;
                    end else if (state_q == S_XFER && sd_rd_valid && cnt_q == LAST_BYTE) begin
                        done_q[owner_q] <= 1'b1;
                        gnt_q           <= '0;
                        state_q         <= S_FINISH;
                    end
                end
                S_FINISH, S_ABORT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0       = gnt_q[0];
    assign gnt1       = gnt_q[1];
    assign valid0     = valid_q[0];
    assign valid1     = valid_q[1];
    assign done0      = done_q[0];
    assign done1      = done_q[1];
    assign err0       = err_q[0];
    assign err1       = err_q[1];
    assign data0      = data0_q;
    assign data1      = data1_q;
    assign sd_rd_req  = sd_rd_req_q;
    assign sd_rd_addr = sd_rd_addr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Self-checking bench for sd_read_arbiter: scoreboarded byte stream plus per-scenario checks.
module tb_sd_read_arbiter;

    localparam int unsigned TB_BLOCK   = 512;
    localparam int unsigned TB_TIMEOUT = 100;

    logic        clk50;
    logic        reset;
    logic        card_ready;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1;
    logic [7:0]  data0, data1;
    logic        valid0, valid1, done0, done1, err0, err1;
    logic        sd_rd_req;
    logic [31:0] sd_rd_addr;
    logic        sd_rd_ack;
    logic [7:0]  sd_rd_data;
    logic        sd_rd_valid;
    logic        sd_rd_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] mon_got;
    logic [17:0] mon_exp;
    logic [57:0] all_outs;

    assign all_outs = {gnt0, gnt1, valid0, valid1, done0, done1, err0, err1,
                       sd_rd_req, busy, data0, data1, sd_rd_addr};

    sd_read_arbiter #(
        .BLOCK_BYTES    (TB_BLOCK),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .ADDR_W         (32)
    ) dut (
        .clk50       (clk50),
        .reset       (reset),
        .card_ready  (card_ready),
        .req0        (req0),
        .addr0       (addr0),
        .gnt0        (gnt0),
        .data0       (data0),
        .valid0      (valid0),
        .done0       (done0),
        .err0        (err0),
        .req1        (req1),
        .addr1       (addr1),
        .gnt1        (gnt1),
        .data1       (data1),
        .valid1      (valid1),
        .done1       (done1),
        .err1        (err1),
        .sd_rd_req   (sd_rd_req),
        .sd_rd_addr  (sd_rd_addr),
        .sd_rd_ack   (sd_rd_ack),
        .sd_rd_data  (sd_rd_data),
        .sd_rd_valid (sd_rd_valid),
        .sd_rd_err   (sd_rd_err),
        .busy        (busy)
    );

    initial begin
        clk50 = 1'b0;
        forever #5 clk50 = ~clk50;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 1000000");
        $fatal(1);
    end

    // Scoreboard: entry is {valid1, valid0, data0, data1}.
    always @(negedge clk50) begin
        if (reset === 1'b1 && (valid0 === 1'b1 || valid1 === 1'b1)) begin
            n_checks++;
            mon_got = {valid1, valid0, data0, data1};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL byte_unexpected: got %h, required no byte", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL byte_stream: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic engine_run(input int ch, input logic [31:0] exp_addr, input int nbytes,
                              input int err_at, input logic [7:0] seed);
        int          w;
        logic [7:0]  b;
        logic [17:0] e;
        w = 0;
        while (sd_rd_req !== 1'b1 && w < 50) begin
            @(posedge clk50); #1;
            w++;
        end
        n_checks++;
        if (sd_rd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL engine_wait_req ch%0d: sd_rd_req=%b, required 1 within 50 cycles", ch, sd_rd_req);
            return;
        end
        n_checks++;
        if (sd_rd_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL sd_rd_addr ch%0d: got %h, required %h", ch, sd_rd_addr, exp_addr);
        end
        n_checks++;
        if ({gnt1, gnt0} !== (ch == 1 ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL grant_owner: got gnt1/gnt0=%b%b, required owner %0d", gnt1, gnt0, ch);
        end
        sd_rd_ack = 1'b1;
        @(posedge clk50); #1;
        sd_rd_ack = 1'b0;
        n_checks++;
        if (sd_rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_drop_after_ack: sd_rd_req=%b, required 0", sd_rd_req);
        end
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(i) ^ seed;
            sd_rd_valid = 1'b1;
            sd_rd_data  = b;
            sd_rd_err   = (i == err_at);
            e = (ch == 1) ? {2'b10, 8'h00, b} : {2'b01, b, 8'h00};
            exp_q.push_back(e);
            @(posedge clk50); #1;
            if (i == 0 || i == nbytes / 2) begin
                n_checks++;
                if ({gnt1, gnt0, valid1, valid0} !== (ch == 1 ? 4'b1010 : 4'b0101)) begin
                    n_fail++;
                    $display("FAIL xfer_grant_valid byte %0d: got gnt1,gnt0,valid1,valid0=%b%b%b%b, required owner %0d",
                             i, gnt1, gnt0, valid1, valid0, ch);
                end
            end
        end
        sd_rd_valid = 1'b0;
        sd_rd_err   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        repeat (3) @(posedge clk50);
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs);
        end
        reset = 1'b1;
        @(posedge clk50); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single();
        card_ready = 1'b1;
        req0  = 1'b1;
        addr0 = 32'h0000_0010;
        @(posedge clk50); #1;
        addr0 = 32'hFFFF_FFFF;
        engine_run(0, 32'h0000_0010, TB_BLOCK, -1, 8'h00);
        n_checks++;
        if ({valid0, done0, err0, gnt0} !== 4'b1100) begin
            n_fail++;
            $display("FAIL single_last_done: got valid0,done0,err0,gnt0=%b%b%b%b, required 1100",
                     valid0, done0, err0, gnt0);
        end
        n_checks++;
        if ({gnt1, valid1, done1, err1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_req1_quiet: got %b, required 0000", {gnt1, valid1, done1, err1});
        end
        req0 = 1'b0;
        @(posedge clk50); #1;
        n_checks++;
        if ({done0, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_done_pulse: got done0,busy=%b%b, required 00", done0, busy);
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic seen;
        req0  = 1'b1;
        addr0 = 32'h0000_0ABC;
        engine_run(0, 32'h0000_0ABC, 101, -1, 8'h5A);
        @(negedge clk50); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_async_mid_xfer: got %h, required 0", all_outs);
        end
        req0 = 1'b0;
        @(posedge clk50); #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk50); #1;
            seen = seen | done0 | done1 | err0 | err1 | busy;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: activity seen=%b, required 0", seen);
        end
    endtask

    task automatic test_contention();
        int ch;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 32'h0000_0100;
        addr1 = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
`ifdef SD_ARB_FIXED_PRIORITY_EN
            ch = 0;
`else
            ch = k % 2;
`endif
            engine_run(ch, (ch == 1) ? 32'h0000_0200 : 32'h0000_0100, TB_BLOCK, -1, 8'(k));
            n_checks++;
            if ({done1, done0} !== (ch == 1 ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL contention_done round %0d: got done1,done0=%b%b, required owner %0d",
                         k, done1, done0, ch);
            end
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(posedge clk50); #1;
            n_checks++;
            if ({busy, gnt1, gnt0} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_gap round %0d: got busy,gnt1,gnt0=%b%b%b, required 000",
                         k, busy, gnt1, gnt0);
            end
        end
    endtask

    task automatic test_engine_err();
        req1  = 1'b1;
        addr1 = 32'h0000_0300;
        engine_run(1, 32'h0000_0300, 38, 37, 8'h11);
        n_checks++;
        if ({valid1, err1, done1, gnt1} !== 4'b1100) begin
            n_fail++;
            $display("FAIL err_byte37: got valid1,err1,done1,gnt1=%b%b%b%b, required 1100",
                     valid1, err1, done1, gnt1);
        end
        req0  = 1'b1;
        addr0 = 32'h0000_0400;
        @(posedge clk50); #1;
        n_checks++;
        if ({err1, done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL err1_single_pulse: got err1,done1=%b%b, required 00", err1, done1);
        end
        engine_run(0, 32'h0000_0400, TB_BLOCK, TB_BLOCK - 1, 8'h22);
        n_checks++;
        if ({valid0, err0, done0, gnt0} !== 4'b1100) begin
            n_fail++;
            $display("FAIL err_last_byte: got valid0,err0,done0,gnt0=%b%b%b%b, required 1100",
                     valid0, err0, done0, gnt0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk50); #1;
    endtask

    task automatic test_timeout();
        int w;
        int c;
        req0  = 1'b1;
        addr0 = 32'h0000_0500;
        w = 0;
        while (gnt0 !== 1'b1 && w < 20) begin
            @(posedge clk50); #1;
            w++;
        end
        n_checks++;
        if ({gnt0, sd_rd_req} !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_issue: got gnt0,sd_rd_req=%b%b, required 11", gnt0, sd_rd_req);
        end
        c = 0;
        while (err0 !== 1'b1 && c < 300) begin
            @(posedge clk50); #1;
            c++;
        end
        n_checks++;
        if (c != TB_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycles: err0 after %0d cycles, required %0d", c, TB_TIMEOUT);
        end
        n_checks++;
        if ({sd_rd_req, gnt0, done0} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_release: got sd_rd_req,gnt0,done0=%b%b%b, required 000",
                     sd_rd_req, gnt0, done0);
        end
        req0 = 1'b0;
        @(posedge clk50); #1;
    endtask

    task automatic test_card_drop();
        logic seen;
        req1  = 1'b1;
        addr1 = 32'h0000_0600;
        engine_run(1, 32'h0000_0600, 50, -1, 8'h33);
        card_ready = 1'b0;
        req0  = 1'b1;
        addr0 = 32'h0000_0700;
        @(posedge clk50); #1;
        n_checks++;
        if ({err1, done1, gnt1} !== 3'b100) begin
            n_fail++;
            $display("FAIL card_drop_abort: got err1,done1,gnt1=%b%b%b, required 100", err1, done1, gnt1);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk50); #1;
            seen = seen | gnt0 | gnt1 | sd_rd_req | busy;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL card_drop_no_grant: activity seen=%b, required 0", seen);
        end
        card_ready = 1'b1;
        engine_run(0, 32'h0000_0700, TB_BLOCK, -1, 8'h44);
        n_checks++;
        if ({done0, err0} !== 2'b10) begin
            n_fail++;
            $display("FAIL card_return_done: got done0,err0=%b%b, required 10", done0, err0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk50); #1;
    endtask

    initial begin
        reset       = 1'b1;
        card_ready  = 1'b0;
        req0        = 1'b0;
        req1        = 1'b0;
        addr0       = '0;
        addr1       = '0;
        sd_rd_ack   = 1'b0;
        sd_rd_data  = '0;
        sd_rd_valid = 1'b0;
        sd_rd_err   = 1'b0;

        test_reset();
        test_single();
        test_reset_mid_xfer();
        test_contention();
        test_engine_err();
        test_timeout();
        test_card_drop();

        repeat (3) @(posedge clk50);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d bytes outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares one SD-card sector-read engine between two requesters (for example a frame loader and a data loader).
- Arbitrates round-robin and locks the grant for one whole block.
- Forwards the engine's byte stream to the granted requester and flags completion, errors and timeouts.
- Sits between the SDCardReader-level read engine (SDclk/SDcs/SDout/SDin side) and client logic; clocked by the 50 MHz system clock.

Parameters:
- BLOCK_BYTES, 512: bytes per read transaction before the grant is released.
- TIMEOUT_CYCLES, 2000000: idle cycles allowed in ISSUE or between bytes in XFER before abort (40 ms at 50 MHz).
- ADDR_W, 32: sector address width.

Ports:
- clk50  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- card_ready  in  1  engine finished card init (engine's done); level.
- req0  in  1  requester 0 read request; level, held until done0/err0.
- addr0  in  ADDR_W  requester 0 sector address; sampled at grant.
- gnt0  out  1  requester 0 owns the engine.
- data0  out  8  byte to requester 0.
- valid0  out  1  data0 qualifier; 1-cycle pulse per byte.
- done0  out  1  1-cycle pulse: block completed for requester 0.
- err0  out  1  1-cycle pulse: block aborted for requester 0.
- req1, addr1, gnt1, data1, valid1, done1, err1: same as above, for requester 1.
- sd_rd_req  out  1  read command to engine; held until sd_rd_ack.
- sd_rd_addr  out  ADDR_W  latched sector address.
- sd_rd_ack  in  1  engine accepted command (1-cycle pulse).
- sd_rd_data  in  8  byte from engine.
- sd_rd_valid  in  1  sd_rd_data qualifier.
- sd_rd_err  in  1  engine error pulse (bad token or CRC).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, rr_ptr=0 (requester 0 favoured), counters 0.
- States: IDLE, ISSUE, XFER, FINISH, ABORT.
- IDLE:
  - Waits for card_ready=1 and at least one reqN.
  - If both requests are high, the requester not equal to rr_ptr loses; rr_ptr names the favoured requester.
  - On the grant edge: latch addrN into sd_rd_addr, set owner, set gntN=1, go to ISSUE.
  - Requests are ignored while card_ready=0.
- ISSUE:
  - sd_rd_req=1.
  - On sd_rd_ack: sd_rd_req=0 next cycle, byte_cnt=0, wdog=0, go to XFER.
- XFER:
  - Each sd_rd_valid registers sd_rd_data into data<owner>, with valid<owner>=1 on the next cycle (latency 1).
  - The non-owner's data is held at 0 and its valid stays 0.
  - byte_cnt increments per byte. The byte accepted at byte_cnt==BLOCK_BYTES-1 moves the state to FINISH.
  - sd_rd_valid outside XFER is ignored.
- FINISH (1 cycle): done<owner>=1, gnt<owner>=0, rr_ptr = other requester, go to IDLE.
- ABORT (1 cycle): err<owner>=1, gnt<owner>=0, rr_ptr = other requester, go to IDLE; done is not pulsed.
- Abort conditions:
  - sd_rd_err in ISSUE or XFER.
  - card_ready falling in ISSUE or XFER.
  - wdog reaches TIMEOUT_CYCLES-1.
  - wdog clears on entry to ISSUE, on sd_rd_ack, and on every sd_rd_valid.
- Simultaneous events:
  - sd_rd_err together with the last valid byte: the byte is forwarded, and ABORT wins over FINISH.
  - The last byte's valid pulse and the done/err pulse occur in the same cycle.
- Requester protocol:
  - Dropping reqN while granted has no effect; the block runs to completion or abort.
  - reqN still high on the return to IDLE counts as a fresh request at the new rr_ptr priority.
  - addrN changes after grant are ignored.
- Back-to-back operation: a minimum of 1 IDLE cycle between transactions.
- Widths:
  - byte_cnt is clog2(BLOCK_BYTES) bits.
  - wdog is clog2(TIMEOUT_CYCLES) bits and saturates, never wraps.

Optional Feature:
- Macro: SD_ARB_FIXED_PRIORITY_EN.
- When defined: rr_ptr is removed and requester 0 always wins simultaneous requests. Requester 1 is granted only when req0=0 in IDLE.
- When undefined: round-robin exactly as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-XFER:
  - Stimulus: assert reset=0 after byte 100 of a transfer.
  - Response: all outputs 0 asynchronously, before the next clk50 edge.
  - After reset=1: IDLE, and no done/err pulse.
- Single request:
  - Stimulus: card_ready=1, req0=1, addr0=0x00000010; engine acks and streams 512 bytes 0x00..0xFF twice.
  - Response: sd_rd_addr=0x10; gnt0 high throughout; 512 valid0 pulses with matching data, each 1 cycle after sd_rd_valid; done0 coincides with the last valid0.
  - Response: gnt1, valid1 and done1 stay 0.
- Contention:
  - Stimulus: req0 and req1 rise in the same cycle and both stay high.
  - Response (default build): grants ordered 0, 1, 0, 1.
  - Response (SD_ARB_FIXED_PRIORITY_EN): requester 0 is re-granted every time while req0 is high.
- Engine error:
  - Stimulus: sd_rd_err pulses at byte 37 of requester 1's block.
  - Response: err1 pulses once, done1 stays 0, gnt1 drops, next grant goes to requester 0.
  - Stimulus: sd_rd_err together with byte 511.
  - Response: byte 511 is forwarded and err pulses, not done.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; engine never acks.
  - Response: err0 pulses exactly 100 cycles after ISSUE entry; sd_rd_req drops.
- Card drop:
  - Stimulus: card_ready falls during XFER.
  - Response: ABORT with err pulse; new requests are not granted until card_ready=1.
